// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU op codes,
// FSM state encoding and the default operand width.
package mdu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [4:0] OP_MUL   = 5'd17;
    localparam logic [4:0] OP_MULH  = 5'd18;
    localparam logic [4:0] OP_MULHU = 5'd19;
    localparam logic [4:0] OP_DIV   = 5'd20;
    localparam logic [4:0] OP_DIVU  = 5'd21;
    localparam logic [4:0] OP_REM   = 5'd22;
    localparam logic [4:0] OP_REMU  = 5'd23;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Ops that work on operand magnitudes and restore the sign afterwards.
    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_dp.sv
// Iterative datapath: radix-2 shift-add multiplier and restoring divider
// sharing one operand register, plus the combinational sign fixup/select.
module mdu_iter_dp
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step_mul,
    input  logic              i_step_div,
    input  logic [XLEN-1:0]   i_op_a,
    input  logic [XLEN-1:0]   i_op_b,
    input  logic [4:0]        i_op,
    input  logic              i_sign_diff,
    input  logic              i_sign_a,
    output logic [XLEN-1:0]   o_fix_val
);

    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_quot;
    logic [XLEN-1:0]   r_rem;

    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;

    // One multiply or divide iteration worth of arithmetic.
    always_comb begin
        w_addend = r_prod[0] ? r_opb : '0;
        w_sum    = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, w_addend};
        // Shifted partial remainder can exceed XLEN bits by one before the subtract.
        w_rem_sh = {r_rem, r_quot[XLEN-1]};
        w_ge     = (w_rem_sh >= {1'b0, r_opb});
        // When w_ge holds the true difference fits in XLEN bits.
        w_diff   = w_rem_sh[XLEN-1:0] - r_opb;
    end

    // Operand load and per-cycle iteration of product / remainder / quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_opb  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
        end else if (i_load) begin
            r_prod <= {{XLEN{1'b0}}, i_op_a};
            r_opb  <= i_op_b;
            r_quot <= i_op_a;
            r_rem  <= '0;
        end else if (i_step_mul) begin
            r_prod <= {w_sum, r_prod[XLEN-1:1]};
        end else if (i_step_div) begin
            r_rem  <= w_ge ? w_diff : w_rem_sh[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], w_ge};
        end
    end

    // Sign restoration and result word selection; sign flags are zero for unsigned ops.
    always_comb begin
        w_prod_fix = i_sign_diff ? -r_prod : r_prod;
        w_quot_fix = i_sign_diff ? -r_quot : r_quot;
        w_rem_fix  = i_sign_a    ? -r_rem  : r_rem;
        case (i_op)
            OP_MUL:            o_fix_val = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHU: o_fix_val = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:   o_fix_val = w_quot_fix;
            OP_REM, OP_REMU:   o_fix_val = w_rem_fix;
            default:           o_fix_val = '0;
        endcase
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle mul/div sequencer for the EX stage: accepts one op per
// handshake, resolves M-extension corner cases on a fast path, otherwise
// iterates XLEN cycles in mdu_iter_dp and holds the result until consumed.
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 5          // 2**CNT_W must be >= XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        alu_op,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              busy
);

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    mdu_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_op;
    logic              r_s1neg;
    logic              r_s2neg;
    logic [XLEN-1:0]   r_result;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_busy;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_signed;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_val;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_load;
    logic              w_step_mul;
    logic              w_step_div;
    logic [XLEN-1:0]   w_fix_val;

    // Decode the incoming request: magnitudes, fast-path detection and its result.
    always_comb begin
        w_accept   = in_valid && r_in_ready;
        w_is_mul   = is_mul_op(alu_op);
        w_signed   = is_signed_op(alu_op);
        w_ovf      = (src1 == INT_MIN) && (src2 == '1);
        w_a_mag    = (w_signed && src1[XLEN-1]) ? -src1 : src1;
        w_b_mag    = (w_signed && src2[XLEN-1]) ? -src2 : src2;
        w_fast     = 1'b0;
        w_fast_val = '0;
        if (!(w_is_mul || is_div_op(alu_op))) begin
            w_fast = 1'b1;
        end else if (((alu_op == OP_DIV) || (alu_op == OP_DIVU)) && (src2 == '0)) begin
            w_fast     = 1'b1;
            w_fast_val = '1;
        end else if (((alu_op == OP_REM) || (alu_op == OP_REMU)) && (src2 == '0)) begin
            w_fast     = 1'b1;
            w_fast_val = src1;
        end else if ((alu_op == OP_DIV) && w_ovf) begin
            w_fast     = 1'b1;
            w_fast_val = INT_MIN;
        end else if ((alu_op == OP_REM) && w_ovf) begin
            w_fast     = 1'b1;
        end
    end

    // Datapath strobes; flush suppresses both loading and iterating.
    always_comb begin
        w_load     = w_accept && !flush;
        w_step_mul = (r_state == MUL) && !flush;
        w_step_div = (r_state == DIV) && !flush;
    end

    mdu_iter_dp #(
        .XLEN        (XLEN)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_step_mul  (w_step_mul),
        .i_step_div  (w_step_div),
        .i_op_a      (w_a_mag),
        .i_op_b      (w_b_mag),
        .i_op        (r_op),
        .i_sign_diff (r_s1neg ^ r_s2neg),
        .i_sign_a    (r_s1neg),
        .o_fix_val   (w_fix_val)
    );

    // Sequencer FSM with registered handshake outputs; flush overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_s1neg     <= 1'b0;
            r_s2neg     <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op       <= alu_op;
                        r_s1neg    <= w_signed && src1[XLEN-1];
                        r_s2neg    <= w_signed && src2[XLEN-1];
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_fast) begin
                            r_result    <= w_fast_val;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_is_mul) begin
                            r_state <= MUL;
                        end else begin
                            r_state <= DIV;
                        end
                    end
                end
                MUL, DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FIXUP;
                    end
                end
                FIXUP: begin
                    r_result    <= w_fix_val;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed M-extension cases,
// backpressure, flush/reset aborts and randomized ops against a plain
// arithmetic reference model.
module tb_mdu_seq_ctrl;

    localparam logic [4:0] T_MUL = 5'd17, T_MULH = 5'd18, T_MULHU = 5'd19;
    localparam logic [4:0] T_DIV = 5'd20, T_DIVU = 5'd21, T_REM = 5'd22, T_REMU = 5'd23;
    localparam int         ITER_LAT = 34;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mdu_seq_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from RISC-V M-extension semantics using wide integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        int              ia = int'(a);
        int              ib = int'(b);
        logic [63:0]     t;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            T_MUL:   begin t = ua * ub; return t[31:0];  end
            T_MULH:  begin t = sa * sb; return t[63:32]; end
            T_MULHU: begin t = ua * ub; return t[63:32]; end
            T_DIV:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
            T_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            T_REM:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
            T_REMU:  return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Edges from accept (counted as edge 1) until out_valid is seen.
    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op < T_MUL || op > T_REMU) return 1;
        if (op >= T_DIV && b == 0) return 1;
        if ((op == T_DIV || op == T_REM) && ovf) return 1;
        return ITER_LAT;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request; returns #1 after the accept edge with inputs scrambled.
    task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        src1     = a;
        src2     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_op   = 5'($urandom);
        src1     = $urandom;
        src2     = $urandom;
    endtask

    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] exp_res = ref_result(op, a, b);
        int          exp_lat = ref_lat(op, a, b);
        int          lat;
        logic        busy_ok = 1'b1;
        logic        hold_ok = 1'b1;
        out_ready = (hold == 0);
        start_op(op, a, b);
        lat = 1;
        while (!out_valid && lat < 64) begin
            busy_ok &= busy && !in_ready;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " busy_during_op"}, 64'(busy_ok), 64'd1);
        check({tag, " done_flags"}, 64'({out_valid, in_ready, busy}), 64'(3'b101));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                hold_ok &= (result === exp_res) && out_valid && !in_ready && busy;
            end
            check({tag, " held_under_backpressure"}, 64'(hold_ok), 64'd1);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, " consumed"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
        out_ready = 1'b0;
    endtask

    // Watch a window of cycles and report whether out_valid ever rose.
    task automatic no_valid_window(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check({tag, " no_out_valid"}, 64'(seen), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 5'd0;
        src1      = 32'h0;
        src2      = 32'h0;
        #12;
        check("reset flags", 64'({out_valid, in_ready, busy}), 64'(3'b010));
        check("reset result", 64'(result), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("mul 7x-3",          T_MUL,   32'h0000_0007, 32'hFFFF_FFFD, 0);
        do_op("mulh min x min",    T_MULH,  32'h8000_0000, 32'h8000_0000, 0);
        do_op("mulhu max x max",   T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("div -7/2",          T_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0);
        do_op("rem -7/2",          T_REM,   32'hFFFF_FFF9, 32'h0000_0002, 0);
        do_op("divu 100/7",        T_DIVU,  32'd100, 32'd7, 10);
        do_op("remu 100/7",        T_REMU,  32'd100, 32'd7, 0);
        do_op("div 5/0",           T_DIV,   32'd5, 32'd0, 0);
        do_op("remu 5/0",          T_REMU,  32'd5, 32'd0, 0);
        do_op("div ovf",           T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("rem ovf",           T_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("bad op",            5'd5,    32'd9, 32'd3, 0);

        // Flush in the 15th MUL cycle.
        start_op(T_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (14) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush flags", 64'({out_valid, in_ready, busy}), 64'(3'b010));
        no_valid_window("after flush", 40);

        // Asynchronous reset pulse in the 5th DIV cycle.
        start_op(T_DIVU, 32'd1000, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("reset mid-div flags", 64'({out_valid, in_ready, busy}), 64'(3'b010));
        check("reset mid-div result", 64'(result), 64'd0);
        #2;
        rst_n = 1'b1;
        no_valid_window("after reset pulse", 40);
        do_op("divu 9/3 after abort", T_DIVU, 32'd9, 32'd3, 0);

        // Randomized ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic [4:0]  op = 5'($urandom_range(16, 24));
            logic [31:0] a  = pick_operand();
            logic [31:0] b  = pick_operand();
            do_op($sformatf("rand%0d op%0d %h %h", k, op, a, b), op, a, b, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that replaces the single-cycle combinational mul/div operators in the EX-stage ALU.
- Accepts one operation per valid/ready handshake and runs it iteratively: radix-2 shift-add multiply or restoring divide.
- Applies RISC-V M-extension sign and corner-case fixups, then holds the result until the pipeline consumes it.
- The EX stage stalls on busy and on in_ready low.

Parameters:
- XLEN, 32, operand/result width. The iteration count equals XLEN.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W >= XLEN.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill. Aborts any operation and discards any held result.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE.
- alu_op  input  5  ALU op encoding: 17 mul, 18 mulh, 19 mulhu, 20 div, 21 divu, 22 rem, 23 remu.
- src1  input  XLEN  rs1 operand.
- src2  input  XLEN  rs2 operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  final value, stable while out_valid is high.
- busy  output  1  high in any state other than IDLE.

Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0, internal accumulators=0.
- Accept: in_valid && in_ready on an edge latches op, operand signs and operand magnitudes. Unsigned ops use the raw operands; mulh/div/rem use the absolute values. Latching is suppressed if flush is high on the same edge.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- IDLE -> DONE directly on accept for these fast-path cases; out_valid is high 1 cycle after the accept edge:
  - op outside 17..23: result=0.
  - src2==0 with div/divu: result=all ones.
  - src2==0 with rem/remu: result=src1.
  - div with src1=0x80000000 and src2=0xFFFFFFFF: result=0x80000000.
  - rem with that same operand pair: result=0.
- IDLE -> MUL for ops 17-19; IDLE -> DIV for ops 20-23 in all other cases. Counter is cleared.
- MUL iteration (one per cycle): if multiplier LSB is set, add the multiplicand into the upper half of a 2*XLEN product. Then shift right 1.
- DIV iteration (one per cycle, restoring): shift {rem,quot} left 1, trial-subtract the divisor. If non-negative, keep the difference and set the quotient LSB.
- Counter increments each iteration. After iteration XLEN (counter==XLEN-1 at the edge) go to FIXUP.
- FIXUP (1 cycle):
  - mulh: negate the 64-bit product if the operand signs differ.
  - div: negate the quotient if the operand signs differ.
  - rem: negate the remainder if src1 was negative.
  - Select the output: low word for mul; high word for mulh/mulhu; quotient or remainder for div/rem.
  - Go to DONE.
- Latency: accept edge to out_valid = XLEN+2 edges (34 at default).
- DONE: out_valid=1 and result is held. out_valid && out_ready -> IDLE.
  - in_ready stays low in DONE; there is no back-to-back accept in the same cycle as result consumption.
- flush has priority over every transition. Next state is IDLE with out_valid=0; the result register keeps its value but is invalid.
- rst_n asserted mid-operation: immediate return to reset values; no partial result is ever presented.
- Input operands may change after acceptance; the computation uses only the latched copies.

Decomposition:
- Shared package mdu_pkg holds:
  - ALU op constants 17..23 under the same names as the ALU (OP_MUL ... OP_REMU).
  - State enum (IDLE, MUL, DIV, FIXUP, DONE).
  - XLEN default.
- One natural sub-module, mdu_iter_dp: shift/add/subtract datapath with product, remainder and quotient registers, driven by step/load/fixup strobes from the FSM in mdu_seq_ctrl.

Test Plan:
- mul 7 x -3 (0x00000007, 0xFFFFFFFD), out_ready=1 -> out_valid at edge 34, result 0xFFFFFFEB; busy high for 34 cycles.
- mulh 0x80000000 x 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 100/7 -> 14; remu 100/7 -> 2.
- Corner cases, each with out_valid 1 cycle after accept:
  - div 5/0 -> 0xFFFFFFFF.
  - remu 5/0 -> 5.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000.
  - rem 0x80000000/0xFFFFFFFF -> 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0. Raise out_ready -> IDLE the next cycle.
- flush in MUL cycle 15, and rst_n pulse in DIV cycle 5 -> state IDLE, out_valid never asserts. A new divu 9/3 afterwards returns 3.
